// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns each chip-select frame into register-bus writes or reads.
// Optional macro SPI_CMD_AUTOINC_EN enables address auto-increment with wrap error.
module spi_cmd_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              spi_cs_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o,
    output logic              err_o,
    input  logic              err_clr_i
);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t            state, next_state;
    logic              cs_meta, cs_sync;
    logic              rx_valid_q;
    logic              read_capture;
    logic [ADDR_W-1:0] addr;

    logic              octet_edge;
    logic              access_busy;
    logic              load_cmd;
    logic              do_write;
    logic              do_read;
    logic              set_err;
    logic              wrap_err;
    logic [ADDR_W-1:0] access_addr;

    assign octet_edge  = rx_valid_i && !rx_valid_q;
    // An access is in flight from its strobe until read data has landed in tx_data_o.
    assign access_busy = reg_we_o || reg_re_o || read_capture;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cs_meta    <= 1'b1;
            cs_sync    <= 1'b1;
            rx_valid_q <= 1'b0;
            state      <= IDLE;
        end else begin
            cs_meta    <= spi_cs_i;
            cs_sync    <= cs_meta;
            rx_valid_q <= rx_valid_i;
            state      <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load_cmd    = 1'b0;
        do_write    = 1'b0;
        do_read     = 1'b0;
        set_err     = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_sync)
                    next_state = CMD;
            end
            default: begin
                // cs rising while an octet is still being processed means the frame was cut short.
                if (cs_sync) begin
                    next_state = IDLE;
                    set_err    = octet_edge || access_busy;
                end else if (octet_edge && access_busy) begin
                    set_err = 1'b1;
                end else if (octet_edge) begin
                    case (state)
                        CMD: begin
                            load_cmd = 1'b1;
                            if (rx_data_i[DATA_W-1]) begin
                                do_read    = 1'b1;
                                next_state = RD;
                            end else begin
                                next_state = WR;
                            end
                        end
                        WR:      do_write = 1'b1;
                        RD:      do_read  = 1'b1;
                        default: next_state = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        access_addr = load_cmd ? rx_data_i[ADDR_W-1:0] : addr;
`ifdef SPI_CMD_AUTOINC_EN
        wrap_err = (do_write || do_read) && (access_addr == {ADDR_W{1'b1}});
`else
        wrap_err = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr         <= '0;
            reg_addr_o   <= '0;
            reg_wdata_o  <= '0;
            reg_we_o     <= 1'b0;
            reg_re_o     <= 1'b0;
            read_capture <= 1'b0;
            tx_data_o    <= '0;
            err_o        <= 1'b0;
        end else begin
            reg_we_o     <= do_write;
            reg_re_o     <= do_read;
            read_capture <= reg_re_o;
            if (do_write || do_read)
                reg_addr_o <= access_addr;
            if (do_write)
                reg_wdata_o <= rx_data_i;
`ifdef SPI_CMD_AUTOINC_EN
            if (do_write || do_read)
                addr <= ADDR_W'(access_addr + 1'b1);
            else if (load_cmd)
                addr <= access_addr;
`else
            if (load_cmd)
                addr <= access_addr;
`endif
            if (next_state == IDLE)
                tx_data_o <= '0;
            else if (read_capture)
                tx_data_o <= reg_rdata_i;
            if (set_err || wrap_err)
                err_o <= 1'b1;
            else if (err_clr_i)
                err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl; expectations follow SPI_CMD_AUTOINC_EN.
module tb_spi_cmd_ctrl;

`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk;
    logic       rstN;
    logic       spiCs;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] txData;
    logic [6:0] regAddr;
    logic [7:0] regWdata;
    logic       regWe;
    logic       regRe;
    logic [7:0] regRdata;
    logic       busy;
    logic       err;
    logic       errClr;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [6:0] weAddr[$];
    logic [7:0] weData[$];
    logic [6:0] reAddr[$];

    spi_cmd_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_n_i    (rstN),
        .spi_cs_i   (spiCs),
        .rx_data_i  (rxData),
        .rx_valid_i (rxValid),
        .tx_data_o  (txData),
        .reg_addr_o (regAddr),
        .reg_wdata_o(regWdata),
        .reg_we_o   (regWe),
        .reg_re_o   (regRe),
        .reg_rdata_i(regRdata),
        .busy_o     (busy),
        .err_o      (err),
        .err_clr_i  (errClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every strobe and act as a register file that returns addr ^ 0x5A the cycle after a read.
    always @(negedge clk) begin
        if (regWe) begin
            weAddr.push_back(regAddr);
            weData.push_back(regWdata);
        end
        if (regRe) begin
            reAddr.push_back(regAddr);
            regRdata = {1'b0, regAddr} ^ 8'h5A;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] octet, input int hold);
        @(negedge clk);
        rxData  = octet;
        rxValid = 1'b1;
        repeat (hold) @(negedge clk);
        rxValid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic startFrame();
        weAddr.delete();
        weData.delete();
        reAddr.delete();
        @(negedge clk);
        spiCs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic endFrame();
        @(negedge clk);
        spiCs = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rstN     = 1'b0;
        spiCs    = 1'b1;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        regRdata = 8'h00;
        errClr   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx",    txData,   8'h00);
        checkOutput("rst_addr",  regAddr,  7'h00);
        checkOutput("rst_wdata", regWdata, 8'h00);
        checkOutput("rst_we",    regWe,    1'b0);
        checkOutput("rst_re",    regRe,    1'b0);
        checkOutput("rst_busy",  busy,     1'b0);
        checkOutput("rst_err",   err,      1'b0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);

        // Write burst
        startFrame();
        checkOutput("wr_busy_on", busy, 1'b1);
        applyStimulus(8'h05, 2);
        applyStimulus(8'hA1, 2);
        applyStimulus(8'hB2, 2);
        endFrame();
        checkOutput("wr_busy_off", busy, 1'b0);
        checkOutput("wr_count", weAddr.size(), 2);
        checkOutput("wr_addr0", weAddr[0], 7'h05);
        checkOutput("wr_data0", weData[0], 8'hA1);
        checkOutput("wr_addr1", weAddr[1], AUTOINC ? 7'h06 : 7'h05);
        checkOutput("wr_data1", weData[1], 8'hB2);
        checkOutput("wr_err", err, 1'b0);

        // Read burst
        startFrame();
        applyStimulus(8'h83, 2);
        checkOutput("rd_tx0", txData, 8'h59);
        applyStimulus(8'h00, 2);
        checkOutput("rd_tx1", txData, AUTOINC ? 8'h5E : 8'h59);
        applyStimulus(8'h00, 2);
        checkOutput("rd_tx2", txData, AUTOINC ? 8'h5F : 8'h59);
        endFrame();
        checkOutput("rd_count", reAddr.size(), 3);
        checkOutput("rd_addr0", reAddr[0], 7'h03);
        checkOutput("rd_addr1", reAddr[1], AUTOINC ? 7'h04 : 7'h03);
        checkOutput("rd_addr2", reAddr[2], AUTOINC ? 7'h05 : 7'h03);
        checkOutput("rd_tx_idle", txData, 8'h00);
        checkOutput("rd_wr_none", weAddr.size(), 0);

        // Address wrap
        startFrame();
        applyStimulus(8'h7F, 2);
        applyStimulus(8'h12, 2);
        applyStimulus(8'h34, 2);
        endFrame();
        checkOutput("wrap_count", weAddr.size(), 2);
        checkOutput("wrap_addr0", weAddr[0], 7'h7F);
        checkOutput("wrap_addr1", weAddr[1], AUTOINC ? 7'h00 : 7'h7F);
        checkOutput("wrap_data1", weData[1], 8'h34);
        checkOutput("wrap_err", err, AUTOINC ? 1'b1 : 1'b0);
        @(negedge clk);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        checkOutput("err_clr", err, 1'b0);

        // Abort after command only, then a clean frame
        startFrame();
        applyStimulus(8'h10, 2);
        endFrame();
        checkOutput("abort_we", weAddr.size(), 0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_err", err, 1'b0);
        startFrame();
        applyStimulus(8'h11, 2);
        applyStimulus(8'hCC, 2);
        endFrame();
        checkOutput("post_abort_count", weAddr.size(), 1);
        checkOutput("post_abort_addr", weAddr[0], 7'h11);
        checkOutput("post_abort_data", weData[0], 8'hCC);

        // Asynchronous reset while in WR
        startFrame();
        applyStimulus(8'h20, 2);
        checkOutput("mid_busy", busy, 1'b1);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("mid_rst_addr",  regAddr,  7'h00);
        checkOutput("mid_rst_wdata", regWdata, 8'h00);
        checkOutput("mid_rst_busy",  busy,     1'b0);
        checkOutput("mid_rst_tx",    txData,   8'h00);
        #1 rstN = 1'b1;
        endFrame();
        startFrame();
        applyStimulus(8'h22, 2);
        applyStimulus(8'h77, 2);
        endFrame();
        checkOutput("post_rst_count", weAddr.size(), 1);
        checkOutput("post_rst_addr", weAddr[0], 7'h22);
        checkOutput("post_rst_data", weData[0], 8'h77);

        // rx_valid held high for six cycles
        startFrame();
        applyStimulus(8'h30, 2);
        applyStimulus(8'h9D, 6);
        endFrame();
        checkOutput("held_count", weAddr.size(), 1);
        checkOutput("held_addr", weAddr[0], 7'h30);
        checkOutput("held_data", weData[0], 8'h9D);

        // Second octet edge while a read is still in flight is dropped
        checkOutput("drop_err_pre", err, 1'b0);
        startFrame();
        @(negedge clk);
        rxData  = 8'h85;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        @(negedge clk);
        rxData  = 8'h00;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("drop_tx", txData, 8'h5F);
        endFrame();
        checkOutput("drop_re_count", reAddr.size(), 1);
        checkOutput("drop_err", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer placed between the SPI slave octet engine and the audio shield's internal register bus. Interprets the octet stream of each chip-select frame as one command byte followed by data bytes, then issues single-cycle register writes or reads and supplies the next octet to be shifted out on MISO. Frames end cleanly or are aborted by chip-select deassertion at any point.

## Interface
Parameters:
- ADDR_W, 7: register address width; must be ≤ 7.
- DATA_W, 8: register data width; fixed at 8 (one octet).

Ports:
- clk_i  in  1  system clock; the same clock as the SPI slave.
- rst_n_i  in  1  asynchronous active-low reset.
- spi_cs_i  in  1  raw chip select, active-low, asynchronous to clk_i.
- rx_data_i  in  8  received octet from the slave (writeGlu).
- rx_valid_i  in  1  slave octet-ready flag (newOctet); level, may stay high for several cycles.
- tx_data_o  out  8  octet to transmit next (readGlu).
- reg_addr_o  out  ADDR_W  register address.
- reg_wdata_o  out  8  write data.
- reg_we_o  out  1  write strobe, one cycle wide.
- reg_re_o  out  1  read strobe, one cycle wide.
- reg_rdata_i  in  8  read data; valid the cycle after reg_re_o.
- busy_o  out  1  high while a frame is active (cs low, after synchronisation).
- err_o  out  1  sticky: frame aborted mid-octet, or access past the address limit.
- err_clr_i  in  1  clears err_o.

## Operation
- spi_cs_i passes through a 2-FF synchroniser. rx_valid_i is registered once and rising-edge detected; one detected edge equals one octet.
- Command byte: bit7 = 1 selects read, 0 selects write. bits[ADDR_W-1:0] give the start address; unused bits are ignored.
- FSM states:
  - IDLE: cs high. tx_data_o = 8'h00.
  - CMD: entered when synchronised cs goes low. The first octet is latched as the command. Write commands go to WR. Read commands issue reg_re_o and go to RD.
  - WR: each octet produces one reg_we_o at the current address.
  - RD: each octet (dummy data from the master) issues the read for the next address. Received data is discarded.
- Synchronised cs high returns the FSM to IDLE from any state on the next cycle. No strobe is issued after that point.
- An abort sets err_o only if the last command or data octet edge and cs rise have no whole-octet relationship. The block cannot see partial octets, so cs high in CMD state without any octet does not set err_o.
- Address after each access: addr+1, wrapping from 2^ADDR_W−1 to 0. The wrap sets err_o (see Configuration).
- err_clr_i and a new error in the same cycle: the set wins.

## Timing
- Reset values: tx_data_o=8'h00, reg_addr_o=0, reg_wdata_o=0, reg_we_o=0, reg_re_o=0, busy_o=0, err_o=0, FSM=IDLE.
- cs-low to busy_o: 2–3 clk (synchroniser plus one register).
- Octet edge detected in cycle N:
  - Write: reg_we_o, reg_addr_o and reg_wdata_o are valid in cycle N+1.
  - Read: reg_re_o is valid in N+1 and reg_rdata_i is sampled in N+2. tx_data_o holds the new value from N+3 until the next read completes.
- The master must allow at least 4 clk between the last SCK edge of an octet and the first SCK edge of the next. At an SCK period ≥ 8 clk this holds inherently.
- A second rx_valid_i rising edge arriving before the previous access completes is dropped and sets err_o.

## Configuration
- SPI_CMD_AUTOINC_EN defined:
  - The address auto-increments after every data octet, as described above.
  - A wrap past 2^ADDR_W−1 sets err_o.
- SPI_CMD_AUTOINC_EN undefined:
  - The address stays fixed at the command address for the whole frame, for FIFO-style registers.
  - No wrap error exists.

## Test plan
- Write burst: cs low, octets 8'h05, 8'hA1, 8'hB2, cs high. Required: reg_we_o twice, at addr 5 with 8'hA1 and at addr 6 with 8'hB2; busy_o returns to 0.
- Read burst: octets 8'h83, 8'h00, 8'h00 with a register model returning addr^8'h5A. Required: reg_re_o at addresses 3, 4, 5; tx_data_o = 8'h59, then 8'h5E.
- Wrap: write command 8'h7F followed by 2 data octets. Required: writes at 7F and then 00; err_o=1 with AUTOINC_EN, and both writes at 7F with err_o=0 without it.
- Abort: cs deasserted after only the command octet 8'h10. Required: no reg_we_o; FSM returns to IDLE; the next frame 8'h11, 8'hCC writes 8'hCC to addr 0x11.
- Reset mid-frame: assert rst_n_i low during WR. Required: all outputs take their reset values immediately (asynchronous); the next frame decodes correctly.
- Held rx_valid_i: rx_valid_i high for 6 cycles on one octet. Required: exactly one strobe.
